// File: rtl/ps2_pkg.sv
// Shared constants and decoder state encoding for the PS/2 scancode receiver.
package ps2_pkg;
   localparam logic [7:0] PS2_BREAK      = 8'hF0;
   localparam logic [7:0] PS2_EXT        = 8'hE0;
   localparam int         PS2_FRAME_BITS = 11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXT   = 2'd1,
      BREAK = 2'd2
   } dec_state_t;
endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame deserialiser: pin synchronisers, falling-edge detect, 11-bit
// framing with odd parity and a mid-frame idle timeout.
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_data,
   output logic       o_byte_valid,
   output logic [7:0] o_byte,
   output logic       o_frame_err
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic          r_clk_s1, r_clk_s2, r_clk_s3;
   logic          r_dat_s1, r_dat_s2;
   logic [3:0]    r_bitcnt;
   logic [9:0]    r_shift;
   logic [CW-1:0] r_idle;

   logic w_fall, w_last, w_ok, w_timeout;

   always_comb begin
      w_fall    = r_clk_s3 & ~r_clk_s2;
      w_last    = w_fall && (r_bitcnt == 4'(PS2_FRAME_BITS - 1));
      // r_shift holds {parity, d7..d0, start}; the live data bit is the stop bit
      w_ok      = ~r_shift[0] & r_dat_s2 & (^r_shift[9:1]);
      w_timeout = !w_fall && (r_bitcnt != 4'd0) && (r_idle == CW'(TIMEOUT_CYCLES));
      o_byte_valid = w_last & w_ok;
      o_byte       = r_shift[8:1];
      o_frame_err  = (w_last & ~w_ok) | w_timeout;
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_clk_s1 <= 1'b1;
         r_clk_s2 <= 1'b1;
         r_clk_s3 <= 1'b1;
         r_dat_s1 <= 1'b1;
         r_dat_s2 <= 1'b1;
         r_bitcnt <= 4'd0;
         r_shift  <= 10'd0;
         r_idle   <= '0;
      end else begin
         r_clk_s1 <= i_ps2_clk;
         r_clk_s2 <= r_clk_s1;
         r_clk_s3 <= r_clk_s2;
         r_dat_s1 <= i_ps2_data;
         r_dat_s2 <= r_dat_s1;
         if (w_fall) begin
            r_idle <= '0;
            if (w_last) begin
               r_bitcnt <= 4'd0;
            end else begin
               r_bitcnt <= r_bitcnt + 4'd1;
               r_shift  <= {r_dat_s2, r_shift[9:1]};
            end
         end else if (w_timeout) begin
            r_bitcnt <= 4'd0;
            r_idle   <= '0;
         end else if (r_bitcnt != 4'd0) begin
            r_idle <= r_idle + CW'(1);
         end
      end
   end
endmodule

// File: rtl/ps2_scancode_rx.sv
// Keyboard front end: strips E0/F0 prefixes, tracks the held key and writes
// each new press to the translation RAM at a monotonically advancing address.
module ps2_scancode_rx
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int ADDR_W         = 8
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              ps2_clk,
   input  logic              ps2_data,
   output logic              we,
   output logic [ADDR_W-1:0] inaddr,
   output logic [7:0]        din,
   output logic              pressed,
   output logic [7:0]        cur_code,
   output logic              frame_err,
   output logic [7:0]        key_count,
   output logic [1:0]        dbg_state
);
   logic       w_byte_valid, w_rx_err;
   logic [7:0] w_byte;

   ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_frame_rx (
      .clk          (clk),
      .clrn         (clrn),
      .i_ps2_clk    (ps2_clk),
      .i_ps2_data   (ps2_data),
      .o_byte_valid (w_byte_valid),
      .o_byte       (w_byte),
      .o_frame_err  (w_rx_err)
   );

   dec_state_t        r_state, w_state_nxt;
   logic              r_we, r_pressed, r_frame_err;
   logic [ADDR_W-1:0] r_wptr, r_inaddr;
   logic [7:0]        r_din, r_cur_code, r_key_count;
   logic              w_make, w_release, w_write;

   always_comb begin
      w_state_nxt = r_state;
      w_make      = 1'b0;
      w_release   = 1'b0;
      if (w_byte_valid) begin
         case (r_state)
            IDLE: begin
               if (w_byte == PS2_EXT)        w_state_nxt = EXT;
               else if (w_byte == PS2_BREAK) w_state_nxt = BREAK;
               else                          w_make      = 1'b1;
            end
            EXT: begin
               if (w_byte == PS2_BREAK) begin
                  w_state_nxt = BREAK;
               end else begin
                  w_make      = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
            BREAK: begin
               w_release   = 1'b1;
               w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
      // A make of the key already held is typematic repeat and is not written
      w_write = w_make && !(r_pressed && (w_byte == r_cur_code));
   end

   // we is a one-cycle valid with no ready: the RAM always accepts, and
   // inaddr/din are stable while we=1 and hold afterwards.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_state     <= IDLE;
         r_we        <= 1'b0;
         r_wptr      <= '0;
         r_inaddr    <= '0;
         r_din       <= 8'd0;
         r_pressed   <= 1'b0;
         r_cur_code  <= 8'd0;
         r_frame_err <= 1'b0;
         r_key_count <= 8'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_we        <= w_write;
         r_frame_err <= w_rx_err;
         if (w_write) begin
            r_din       <= w_byte;
            r_inaddr    <= r_wptr;
            r_wptr      <= r_wptr + ADDR_W'(1);
            r_cur_code  <= w_byte;
            r_pressed   <= 1'b1;
            r_key_count <= r_key_count + 8'd1;
         end else if (w_release && (w_byte == r_cur_code)) begin
            r_pressed <= 1'b0;
         end
      end
   end

   assign we        = r_we;
   assign inaddr    = r_inaddr;
   assign din       = r_din;
   assign pressed   = r_pressed;
   assign cur_code  = r_cur_code;
   assign frame_err = r_frame_err;
   assign key_count = r_key_count;
   assign dbg_state = r_state;
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: table of frames with hand-computed
// decoder results, then wrap-around, timeout and mid-frame reset sequences.
module tb_ps2_scancode_rx;
   localparam int TO   = 100;
   localparam int AW   = 8;
   localparam int HALF = 4;
   localparam int GAP  = 10;

   logic          clk = 1'b0;
   logic          clrn, ps2_clk, ps2_data;
   logic          we, pressed, frame_err;
   logic [AW-1:0] inaddr;
   logic [7:0]    din, cur_code, key_count;
   logic [1:0]    dbg_state;

   always #5 clk = ~clk;

   ps2_scancode_rx #(.TIMEOUT_CYCLES(TO), .ADDR_W(AW)) dut (
      .clk       (clk),
      .clrn      (clrn),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .we        (we),
      .inaddr    (inaddr),
      .din       (din),
      .pressed   (pressed),
      .cur_code  (cur_code),
      .frame_err (frame_err),
      .key_count (key_count),
      .dbg_state (dbg_state)
   );

   typedef struct {
      logic [7:0] code;
      logic [1:0] bad;      // 0 clean, 1 even parity, 2 stop bit 0
      logic       exp_we;
      logic       exp_pr;
      logic [7:0] exp_cur;
      logic [7:0] exp_kc;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs[$];
   int   n_pass = 0, n_total = 0;
   int   wr_cnt = 0, ferr_cnt = 0;
   logic [AW+7:0] got_q[$];   // observed {inaddr, din} writes
   logic [AW+7:0] exp_q[$];   // expected {inaddr, din} writes

   always @(negedge clk) begin
      if (we) begin
         wr_cnt++;
         got_q.push_back({inaddr, din});
      end
      if (frame_err) ferr_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic add(input logic [7:0] c, input logic [1:0] b, input logic w,
                      input logic p, input logic [7:0] cur, input logic [7:0] kc,
                      input logic fe);
      vec_t v;
      v.code = c; v.bad = b; v.exp_we = w; v.exp_pr = p;
      v.exp_cur = cur; v.exp_kc = kc; v.exp_ferr = fe;
      vecs.push_back(v);
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] code, input logic [1:0] bad);
      logic par;
      par = ~^code;
      if (bad == 2'd1) par = ~par;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(code[i]);
      send_bit(par);
      send_bit(bad == 2'd2 ? 1'b0 : 1'b1);
      ps2_data = 1'b1;
      repeat (GAP) @(negedge clk);
      #1;
   endtask

   task automatic send_partial(input int nbits);
      logic [7:0] pat;
      pat = 8'h5A;
      send_bit(1'b0);
      for (int i = 0; i < nbits - 1; i++) send_bit(pat[i]);
      ps2_data = 1'b1;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      clrn = 1'b0;
      repeat (3) @(negedge clk);
      clrn = 1'b1;
      repeat (2) @(negedge clk);
      #1;
   endtask

   // Pops the oldest observed write and compares it with the oldest expected one
   task automatic check_write(input string name);
      logic [AW+7:0] e;
      e = exp_q.pop_front();
      if (got_q.size() > 0) check(name, 32'(got_q.pop_front()), 32'(e));
      else check({name, "_present"}, 32'(0), 32'(1));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_we"},        32'(we),        32'(0));
      check({tag, "_inaddr"},    32'(inaddr),    32'(0));
      check({tag, "_din"},       32'(din),       32'(0));
      check({tag, "_pressed"},   32'(pressed),   32'(0));
      check({tag, "_cur_code"},  32'(cur_code),  32'(0));
      check({tag, "_frame_err"}, 32'(frame_err), 32'(0));
      check({tag, "_key_count"}, 32'(key_count), 32'(0));
      check({tag, "_state"},     32'(dbg_state), 32'(0));
   endtask

   initial begin
      logic [AW-1:0] exp_ptr;
      logic [7:0]    hold_din;
      logic [7:0]    code;
      int            w0, f0;

      clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
      repeat (4) @(negedge clk);
      clrn = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs("reset");

      //  code  bad  we pr  cur    kc  ferr
      add(8'h1C, 0, 1, 1, 8'h1C, 1, 0);   // single press
      add(8'hF0, 0, 0, 1, 8'h1C, 1, 0);
      add(8'h1C, 0, 0, 0, 8'h1C, 1, 0);   // release
      add(8'h1C, 0, 1, 1, 8'h1C, 2, 0);   // typematic run
      for (int i = 0; i < 4; i++) add(8'h1C, 0, 0, 1, 8'h1C, 2, 0);
      add(8'hF0, 0, 0, 1, 8'h1C, 2, 0);
      add(8'h1C, 0, 0, 0, 8'h1C, 2, 0);
      add(8'hE0, 0, 0, 0, 8'h1C, 2, 0);   // extended press
      add(8'h75, 0, 1, 1, 8'h75, 3, 0);
      add(8'hE0, 0, 0, 1, 8'h75, 3, 0);   // extended release
      add(8'hF0, 0, 0, 1, 8'h75, 3, 0);
      add(8'h75, 0, 0, 0, 8'h75, 3, 0);
      add(8'h1C, 1, 0, 0, 8'h75, 3, 1);   // parity error dropped
      add(8'h32, 0, 1, 1, 8'h32, 4, 0);
      add(8'hF0, 2, 0, 1, 8'h32, 4, 1);   // bad stop: F0 must be dropped
      add(8'h1C, 0, 1, 1, 8'h1C, 5, 0);   // so this is a make, not a release
      add(8'hF0, 0, 0, 1, 8'h1C, 5, 0);
      add(8'h32, 0, 0, 1, 8'h1C, 5, 0);   // release of untracked key
      add(8'hF0, 0, 0, 1, 8'h1C, 5, 0);
      add(8'h1C, 0, 0, 0, 8'h1C, 5, 0);

      exp_ptr  = '0;
      hold_din = 8'h00;
      for (int i = 0; i < vecs.size(); i++) begin
         w0 = wr_cnt; f0 = ferr_cnt;
         send_frame(vecs[i].code, vecs[i].bad);
         check($sformatf("v%0d_we_cnt", i), 32'(wr_cnt - w0), 32'(vecs[i].exp_we));
         if (vecs[i].exp_we) begin
            exp_q.push_back({exp_ptr, vecs[i].code});
            hold_din = vecs[i].code;
            exp_ptr++;
            check_write($sformatf("v%0d_write", i));
         end
         check($sformatf("v%0d_din_hold", i), 32'(din),       32'(hold_din));
         check($sformatf("v%0d_pressed", i),  32'(pressed),   32'(vecs[i].exp_pr));
         check($sformatf("v%0d_cur_code", i), 32'(cur_code),  32'(vecs[i].exp_cur));
         check($sformatf("v%0d_key_cnt", i),  32'(key_count), 32'(vecs[i].exp_kc));
         check($sformatf("v%0d_ferr_cnt", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
      end

      // Address wrap: 257 alternating presses from a fresh reset
      pulse_reset();
      got_q.delete();
      exp_ptr = '0;
      for (int i = 0; i < 257; i++) begin
         code = i[0] ? 8'h32 : 8'h1C;
         w0 = wr_cnt;
         send_frame(code, 2'd0);
         check($sformatf("wrap%0d_we_cnt", i), 32'(wr_cnt - w0), 32'(1));
         exp_q.push_back({exp_ptr, code});
         exp_ptr++;
         check_write($sformatf("wrap%0d_write", i));
      end
      check("wrap_key_count", 32'(key_count), 32'(1));
      check("wrap_inaddr",    32'(inaddr),    32'(0));

      // Timeout after 5 bits, then a clean frame (32 differs from held 1C)
      w0 = wr_cnt; f0 = ferr_cnt;
      send_partial(5);
      repeat (TO + 50) @(negedge clk);
      #1;
      check("timeout_ferr_cnt", 32'(ferr_cnt - f0), 32'(1));
      check("timeout_we_cnt",   32'(wr_cnt - w0),   32'(0));
      send_frame(8'h32, 2'd0);
      exp_q.push_back({8'h01, 8'h32});
      check_write("timeout_next_write");
      check("timeout_next_kc", 32'(key_count), 32'(2));

      // Reset mid-frame: no write, no frame_err, outputs at reset values
      w0 = wr_cnt; f0 = ferr_cnt;
      send_partial(5);
      pulse_reset();
      repeat (TO + 50) @(negedge clk);
      #1;
      check("rst_ferr_cnt", 32'(ferr_cnt - f0), 32'(0));
      check("rst_we_cnt",   32'(wr_cnt - w0),   32'(0));
      check_reset_outputs("midrst");
      send_frame(8'h1C, 2'd0);
      exp_q.push_back({8'h00, 8'h1C});
      check_write("rst_next_write");
      check("rst_next_kc",      32'(key_count), 32'(1));
      check("rst_next_pressed", 32'(pressed),   32'(1));
      check("stray_writes",     32'(got_q.size()), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
